rng_stream: RTL and testbench

//  Parametrised successor to the LFSR/CASR random-number generator: 43-bit Galois LFSR XOR 37-bit

---
 rtl/rng_pkg.sv | 54 +++++
 rtl/rng_fifo.sv | 84 ++++++++
 rtl/rng_stream.sv | 105 ++++++++++
 tb/tb_rng_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared constants and step functions for the LFSR/CASR random stream.
package rng_pkg;

    localparam int LFSR_W = 43;
    localparam int CASR_W = 37;
    localparam int SEED_W = 32;

    // Feedback from bit 42 lands on bits 0, 1, 20 and 41 after the shift.
    localparam logic [LFSR_W-1:0] LFSR_TAPS =
        (LFSR_W'(1) << 1) | (LFSR_W'(1) << 20) | (LFSR_W'(1) << 41);

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } gen_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] o
    );
        logic [LFSR_W-1:0] n;
        n = {o[LFSR_W-2:0], o[LFSR_W-1]};
        n = n ^ ({LFSR_W{o[LFSR_W-1]}} & LFSR_TAPS);
        return n;
    endfunction

    function automatic logic [CASR_W-1:0] casr_step(
        input logic [CASR_W-1:0] o,
        input int unsigned       bit150
    );
        logic [CASR_W-1:0] n;
        n = {o[CASR_W-2:0], o[CASR_W-1]} ^ {o[0], o[CASR_W-1:1]};
        n = n ^ (o & (CASR_W'(1) << bit150));
        return n;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_seed(
        input logic [SEED_W-1:0] s
    );
        logic [LFSR_W-1:0] v;
        v = {{(LFSR_W-SEED_W){1'b0}}, s};
        if (v == '0) v = LFSR_W'(1);
        return v;
    endfunction

    function automatic logic [CASR_W-1:0] casr_seed(
        input logic [SEED_W-1:0] s
    );
        logic [CASR_W-1:0] v;
        v = {{(CASR_W-SEED_W){1'b0}}, s};
        if (v == '0) v = CASR_W'(1);
        return v;
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Show-ahead FIFO with registered head word, valid flag, level and flush.
import rng_pkg::*;

module rng_fifo #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [OUT_W-1:0]           data_i,
    input  logic                       pop_i,
    output logic [OUT_W-1:0]           data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop, do_push;

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != LW'(DEPTH)) || do_pop);
        if (do_pop) rd_d = rd_q + 1'b1;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
        // Head is looked up from next-state storage so the output stays a flop.
        valid_d = (cnt_d != '0);
        head_d  = valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign level_o = cnt_q;

endmodule

// File: rtl/rng_stream.sv
// LFSR xor CASR random word stream with warm-up, seed load and output FIFO.
import rng_pkg::*;

module rng_stream #(
    parameter int OUT_W        = 32,
    parameter int DEPTH        = 4,
    parameter int WARMUP_CYC   = 64,
    parameter int CASR_150_BIT = 27
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic                       loadseed_i,
    input  logic [31:0]                seed_i,
    output logic [OUT_W-1:0]           number_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int CW = $clog2(WARMUP_CYC + 2);
    localparam logic [CW-1:0] WARM_INIT = CW'(WARMUP_CYC);
    localparam gen_state_e ST_INIT =
        (WARMUP_CYC == 0) ? ST_RUN : ST_WARM;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CASR_W-1:0] casr_q, casr_d;
    gen_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              push, pop, full;
    logic [OUT_W-1:0]  word;

    assign word = lfsr_q[OUT_W-1:0] ^ casr_q[OUT_W-1:0];
    assign pop  = valid_o & ready_i;

    always_comb begin
        lfsr_d  = lfsr_q;
        casr_d  = casr_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (loadseed_i) begin
            lfsr_d  = lfsr_seed(seed_i);
            casr_d  = casr_seed(seed_i);
            state_d = ST_INIT;
            cnt_d   = WARM_INIT;
        end else begin
            unique case (state_q)
                ST_WARM: begin
                    lfsr_d = lfsr_step(lfsr_q);
                    casr_d = casr_step(casr_q, CASR_150_BIT);
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Step only on push so stalls never skip a word.
                    push = enable_i && (!full || pop);
                    if (push) begin
                        lfsr_d = lfsr_step(lfsr_q);
                        casr_d = casr_step(casr_q, CASR_150_BIT);
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
        busy_d = (state_d == ST_WARM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= LFSR_W'(1);
            casr_q  <= CASR_W'(1);
            state_q <= ST_INIT;
            cnt_q   <= WARM_INIT;
            busy_q  <= (ST_INIT == ST_WARM);
        end else begin
            lfsr_q  <= lfsr_d;
            casr_q  <= casr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

    rng_fifo #(
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (loadseed_i),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (pop),
        .data_o  (number_o),
        .valid_o (valid_o),
        .full_o  (full),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_rng_stream.sv
// Randomised scoreboard bench for rng_stream (default and zero-warm-up builds).
module tb_rng_stream;

    localparam int DEPTH = 4;
    localparam int WARM  = 64;

    logic        clk = 1'b0;
    logic        reset, enable_i, loadseed_i, ready_i;
    logic [31:0] seed_i;
    logic [31:0] num_a, num_b;
    logic        val_a, val_b, busy_a, busy_b;
    logic [2:0]  lvl_a, lvl_b;

    always #5 clk = ~clk;

    rng_stream dut_a (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .loadseed_i(loadseed_i), .seed_i(seed_i),
        .number_o(num_a), .valid_o(val_a), .ready_i(ready_i),
        .busy_o(busy_a), .level_o(lvl_a)
    );

    rng_stream #(.WARMUP_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .loadseed_i(loadseed_i), .seed_i(seed_i),
        .number_o(num_b), .valid_o(val_b), .ready_i(ready_i),
        .busy_o(busy_b), .level_o(lvl_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference generator written straight from the step equations.
    function automatic logic [42:0] m_lfsr(input logic [42:0] o);
        logic [42:0] n;
        n     = {o[41:0], o[42]};
        n[1]  = o[0]  ^ o[42];
        n[20] = o[19] ^ o[42];
        n[41] = o[40] ^ o[42];
        return n;
    endfunction

    function automatic logic [36:0] m_casr(input logic [36:0] o);
        logic [36:0] n;
        for (int i = 0; i < 37; i++) begin
            n[i] = o[(i + 36) % 37] ^ o[(i + 1) % 37];
            if (i == 27) n[i] = n[i] ^ o[i];
        end
        return n;
    endfunction

    logic [42:0] ml [2];
    logic [36:0] mc [2];
    int          mw [2];
    int          mn [2];
    logic [31:0] mq [2][DEPTH];
    logic [31:0] pops_b [$];
    bit          mon = 0;

    task automatic m_adv(input int d, input int wc);
        bit pop, push;
        if (reset) begin
            ml[d] = 43'd1; mc[d] = 37'd1; mn[d] = 0; mw[d] = wc;
        end else if (loadseed_i) begin
            ml[d] = {11'b0, seed_i};
            mc[d] = {5'b0, seed_i};
            if (ml[d] == '0) ml[d] = 43'd1;
            if (mc[d] == '0) mc[d] = 37'd1;
            mn[d] = 0; mw[d] = wc;
        end else if (mw[d] > 0) begin
            ml[d] = m_lfsr(ml[d]); mc[d] = m_casr(mc[d]); mw[d]--;
        end else begin
            pop  = (mn[d] > 0) && ready_i;
            push = enable_i && ((mn[d] < DEPTH) || pop);
            if (pop) begin
                for (int k = 0; k < DEPTH - 1; k++) mq[d][k] = mq[d][k+1];
                mn[d]--;
            end
            if (push) begin
                mq[d][mn[d]] = ml[d][31:0] ^ mc[d][31:0];
                mn[d]++;
                ml[d] = m_lfsr(ml[d]); mc[d] = m_casr(mc[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            chk("a_valid", val_a, mn[0] > 0);
            chk("a_level", lvl_a, mn[0]);
            chk("a_busy", busy_a, mw[0] > 0);
            chk("a_number", num_a, (mn[0] > 0) ? mq[0][0] : 32'd0);
            chk("b_valid", val_b, mn[1] > 0);
            chk("b_level", lvl_b, mn[1]);
            chk("b_busy", busy_b, mw[1] > 0);
            chk("b_number", num_b, (mn[1] > 0) ? mq[1][0] : 32'd0);
            if (val_b && ready_i && !reset && !loadseed_i)
                pops_b.push_back(num_b);
        end
        m_adv(0, WARM);
        m_adv(1, 0);
        if (reset) mon = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          busy_cnt, vbusy;
    bit          found;
    logic [31:0] held;

    initial begin
        reset = 1; enable_i = 0; loadseed_i = 0; ready_i = 0; seed_i = 0;
        chk("pin_lfsr_tap", m_lfsr(43'h400_0000_0000), 43'h200_0010_0003);
        chk("pin_casr_one", m_casr(37'd1), (37'd1 << 36) | 37'd2);
        chk("pin_casr_150", m_casr(37'd1 << 27), 37'h1C00_0000);
        pops_b.delete();
        repeat (3) cyc();

        reset = 0; enable_i = 1; ready_i = 1;
        busy_cnt = 0; vbusy = 0;
        for (int i = 0; i < 150; i++) begin
            if (i == 0) chk("t1_valid_at_release", val_b, 1'b0);
            if (i == 1) chk("t1_valid_latency", val_b, 1'b1);
            if (busy_a) busy_cnt++;
            if (busy_a && val_a) vbusy++;
            cyc();
        end
        chk("t2_busy_cycles", busy_cnt, 64);
        chk("t2_valid_in_warm", vbusy, 0);
        chk("t1_pop_count", pops_b.size() >= 3, 1'b1);
        for (int k = 0; k < 3; k++) chk("t1_word", pops_b[k], 32'h0);

        pops_b.delete();
        loadseed_i = 1; seed_i = 32'h0;
        cyc();
        loadseed_i = 0;
        for (int i = 0; i < 120; i++) begin
            ready_i = 1'($urandom % 2);
            cyc();
        end
        chk("t3_pop_count", pops_b.size() >= 3, 1'b1);
        for (int k = 0; k < 3; k++) chk("t3_word", pops_b[k], 32'h0);

        ready_i = 0; enable_i = 1;
        cyc();
        held = num_a;
        repeat (8) cyc();
        chk("t4_level_full", lvl_a, 3'd4);
        chk("t4_head_held", num_a, held);
        ready_i = 1;
        repeat (20) cyc();

        loadseed_i = 1; seed_i = 32'h1234_5678; ready_i = 0; enable_i = 1;
        cyc();
        loadseed_i = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (lvl_a == 3'd3) found = 1;
        end
        chk("t5_reach_level3", found, 1'b1);
        loadseed_i = 1; seed_i = 32'hDEAD_BEEF; ready_i = 1;
        cyc();
        loadseed_i = 0;
        chk("t5_level", lvl_a, 3'd0);
        chk("t5_valid", val_a, 1'b0);
        chk("t5_busy", busy_a, 1'b1);
        for (int i = 0; i < 150; i++) begin
            ready_i = 1'($urandom % 3 != 0);
            cyc();
        end

        for (int i = 0; i < 1500; i++) begin
            enable_i   = 1'($urandom % 4 != 0);
            ready_i    = 1'($urandom % 3 != 0);
            loadseed_i = 1'($urandom % 200 == 0);
            seed_i     = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            reset      = 1'($urandom % 500 == 0);
            cyc();
        end
        reset = 0; loadseed_i = 0;

        enable_i = 0; ready_i = 1;
        repeat (6) cyc();
        enable_i = 1; ready_i = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (lvl_a == 3'd2) found = 1;
        end
        chk("t6_reach_level2", found, 1'b1);
        reset = 1;
        cyc();
        chk("t6_valid", val_a, 1'b0);
        chk("t6_level", lvl_a, 3'd0);
        chk("t6_number", num_a, 32'h0);
        chk("t6_busy", busy_a, 1'b1);
        reset = 0; ready_i = 1;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
